uart_mux: RTL and testbench
===========================

# uart_mux

Transmit-side framer for the inter-board UART link. On each `send_req` it snapshots the game state (both player positions, ball position, scores, point/end flags) and emits a fixed frame of eight tagged 16-bit words. Each word carries a 4-bit tag in [15:12] and a 12-bit payload in [11:0]. Each word is serialized high byte first into the byte-wide `uart_tx`, so the receiving board's 8-to-16 converter and demux recover it unchanged. It sits between the game-logic registers and `uart_tx`.

## Interface
- `SYNC_PAYLOAD`, 12'h000: payload of the SYNC word.
- `clk`  in  1  system clock; sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `send_req`  in  1  one-cycle request to send a frame (e.g. frame tick).
- `pl1_posx`, `pl1_posy`, `pl2_posx`, `pl2_posy`, `ball_posx`, `ball_posy`  in  12 each  positions.
- `pl1_score`, `pl2_score`  in  4 each  scores.
- `flag_point`, `end_game`  in  1 each  game flags.
- `tx_done`  in  1  one-cycle pulse from `uart_tx`: byte fully sent.
- `tx_start`  out  1  one-cycle pulse: `uart_tx` loads `tx_data`.
- `tx_data`  out  8  byte to send; valid while `tx_start`=1.
- `busy`  out  1  high from snapshot until the cycle after the last `tx_done`.

## Operation
- Frame order (tag:payload): F:SYNC_PAYLOAD, 3:pl1_posx, 4:pl1_posy, 1:pl2_posx, 2:pl2_posy, 5:ball_posx, 6:ball_posy, 7:score. This gives 16 bytes.
- Score payload: [3:0] pl2_score, [7:4] pl1_score, [8] flag_point, [9] end_game, [11:10] 0.
- 4-bit byte index `idx` selects the byte: word = idx[3:1]; idx[0]=0 sends word[15:8], idx[0]=1 sends word[7:0].
- FSM states:
  - IDLE: if `send_req` or `pending`, latch all inputs into the snapshot, clear `pending`, set idx=0, go to SEND.
  - SEND: `tx_start`=1 and `tx_data`=byte(idx) for exactly this cycle; go to WAIT.
  - WAIT: on `tx_done`, if idx=15 go to IDLE; otherwise idx+1 and go to SEND.
- `busy` = (state≠IDLE).
- `send_req` while `busy`: set `pending`. Pending requests saturate at one, so multiple requests yield one extra frame.
- `send_req` in IDLE in the same cycle as `pending`=1 starts a single frame.
- `tx_done` outside WAIT is ignored.
- Frame contents come only from the snapshot. Input changes mid-frame do not affect the frame in flight.
- `rst` mid-frame: the partial frame is abandoned and `pending` is cleared. The receiver resynchronizes on the next SYNC.

## Timing
- Reset values: `tx_start`=0, `tx_data`=8'h00, `busy`=0, state=IDLE, idx=0, `pending`=0, snapshot=0.
- `tx_start` and `tx_data` are registered outputs.
- Latency from request to first byte: `send_req` sampled in cycle N (IDLE) → `tx_start`=1 in N+1 with `tx_data`=8'hF0 (for SYNC_PAYLOAD=0).
- Byte-to-byte: `tx_done` in cycle M → next `tx_start` in M+1.
- Last byte: `tx_done` at idx=15 in cycle M → `busy`=0 in M+1.
- Back-to-back with `pending`=1: snapshot in M+1, `tx_start` in M+2.
- Minimum frame length: 32 cycles plus `uart_tx` byte times.

## Structure
- Shared header `uart_defs.vh`, also used by the receive-side demux:
  - tags SYNC=4'hF, PL2_POSX=4'h1, PL2_POSY=4'h2, PL1_POSX=4'h3, PL1_POSY=4'h4, BALL_POSX=4'h5, BALL_POSY=4'h6, SCORE=4'h7;
  - frame length of 8 words;
  - score-word bit positions.
- Single module with no sub-module. The word-select mux is combinational logic driven by idx and the snapshot.

## Test plan
- Reset: hold `rst` 3 cycles → all outputs 0 and no `tx_start` while `tx_done` toggles.
- Single frame with pl1_posx=12'h123, pl1_score=2, pl2_score=5, flag_point=1 and a tx model replying `tx_done` 10 cycles after each `tx_start` → bytes F0 00 31 23 …; score bytes 71 25; exactly 16 `tx_start` pulses; `busy` falls 1 cycle after the 16th `tx_done`.
- Inputs changed on the cycle after `send_req` → the frame carries the pre-change values.
- Three `send_req` pulses during a frame → exactly one further frame, with its `tx_start` 2 cycles after the final `tx_done`.
- Spurious `tx_done` during IDLE and SEND → no idx advance; byte sequence unchanged.
- `rst` asserted after byte 5 → `tx_start` stays 0. A new `send_req` then restarts the frame at byte F0.

Source files
------------

// File: rtl/uart_mux_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_mux_pkg
// Purpose  : Frame tags, score-word layout and snapshot type for the UART link
// Revision : 1.0
// ============================================================================
package uart_mux_pkg;

    localparam logic [3:0] c_TAG_SYNC      = 4'hF;
    localparam logic [3:0] c_TAG_PL2_POSX  = 4'h1;
    localparam logic [3:0] c_TAG_PL2_POSY  = 4'h2;
    localparam logic [3:0] c_TAG_PL1_POSX  = 4'h3;
    localparam logic [3:0] c_TAG_PL1_POSY  = 4'h4;
    localparam logic [3:0] c_TAG_BALL_POSX = 4'h5;
    localparam logic [3:0] c_TAG_BALL_POSY = 4'h6;
    localparam logic [3:0] c_TAG_SCORE     = 4'h7;

    localparam int c_FRAME_WORDS = 8;
    localparam int c_FRAME_BYTES = 2 * c_FRAME_WORDS;

    localparam int c_SCORE_PL2_LSB   = 0;
    localparam int c_SCORE_PL1_LSB   = 4;
    localparam int c_SCORE_POINT_BIT = 8;
    localparam int c_SCORE_END_BIT   = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [11:0] pl1_posx;
        logic [11:0] pl1_posy;
        logic [11:0] pl2_posx;
        logic [11:0] pl2_posy;
        logic [11:0] ball_posx;
        logic [11:0] ball_posy;
        logic [3:0]  pl1_score;
        logic [3:0]  pl2_score;
        logic        flag_point;
        logic        end_game;
    } snapshot_t;

    function automatic logic [11:0] score_payload(input snapshot_t s);
        logic [11:0] p;
        p = '0;
        p[c_SCORE_PL2_LSB +: 4] = s.pl2_score;
        p[c_SCORE_PL1_LSB +: 4] = s.pl1_score;
        p[c_SCORE_POINT_BIT]    = s.flag_point;
        p[c_SCORE_END_BIT]      = s.end_game;
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_mux_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_mux_if
// Purpose   : Game-state inputs, frame request and uart_tx byte handshake
// Revision  : 1.0
// ============================================================================
interface uart_mux_if;

    logic        send_req;
    logic [11:0] pl1_posx;
    logic [11:0] pl1_posy;
    logic [11:0] pl2_posx;
    logic [11:0] pl2_posy;
    logic [11:0] ball_posx;
    logic [11:0] ball_posy;
    logic [3:0]  pl1_score;
    logic [3:0]  pl2_score;
    logic        flag_point;
    logic        end_game;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;

    modport master (
        output send_req, pl1_posx, pl1_posy, pl2_posx, pl2_posy,
               ball_posx, ball_posy, pl1_score, pl2_score,
               flag_point, end_game, tx_done,
        input  tx_start, tx_data, busy
    );

    modport slave (
        input  send_req, pl1_posx, pl1_posy, pl2_posx, pl2_posy,
               ball_posx, ball_posy, pl1_score, pl2_score,
               flag_point, end_game, tx_done,
        output tx_start, tx_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_mux.sv
`default_nettype none
// ============================================================================
// Module   : uart_mux
// Purpose  : Snapshots game state and streams it as eight tagged 16-bit words,
//            high byte first, into the byte-wide uart_tx
// Revision : 1.0
// ============================================================================
module uart_mux
    import uart_mux_pkg::*;
#(
    parameter logic [11:0] SYNC_PAYLOAD = 12'h000
) (
    input  logic      clk,
    input  logic      rst,
    uart_mux_if.slave bus
);

    localparam logic [3:0] c_LAST_IDX = 4'(c_FRAME_BYTES - 1);

    state_t     r_state;
    logic [3:0] r_idx;
    logic       r_pending;
    snapshot_t  r_snap;
    logic       r_tx_start;
    logic [7:0] r_tx_data;

    snapshot_t   w_live;
    logic [3:0]  w_sel_idx;
    logic [15:0] w_word;
    logic [7:0]  w_byte;

    assign w_live = '{
        pl1_posx:   bus.pl1_posx,
        pl1_posy:   bus.pl1_posy,
        pl2_posx:   bus.pl2_posx,
        pl2_posy:   bus.pl2_posy,
        ball_posx:  bus.ball_posx,
        ball_posy:  bus.ball_posy,
        pl1_score:  bus.pl1_score,
        pl2_score:  bus.pl2_score,
        flag_point: bus.flag_point,
        end_game:   bus.end_game
    };

    // The byte is registered one cycle ahead so tx_start/tx_data are valid
    // exactly in SEND; from IDLE that is byte 0, which never reads the snapshot.
    assign w_sel_idx = (r_state == ST_IDLE) ? 4'd0 : r_idx + 4'd1;

    always_comb begin
        w_word = {c_TAG_SYNC, SYNC_PAYLOAD};
        case (w_sel_idx[3:1])
            3'd0: w_word = {c_TAG_SYNC,      SYNC_PAYLOAD};
            3'd1: w_word = {c_TAG_PL1_POSX,  r_snap.pl1_posx};
            3'd2: w_word = {c_TAG_PL1_POSY,  r_snap.pl1_posy};
            3'd3: w_word = {c_TAG_PL2_POSX,  r_snap.pl2_posx};
            3'd4: w_word = {c_TAG_PL2_POSY,  r_snap.pl2_posy};
            3'd5: w_word = {c_TAG_BALL_POSX, r_snap.ball_posx};
            3'd6: w_word = {c_TAG_BALL_POSY, r_snap.ball_posy};
            3'd7: w_word = {c_TAG_SCORE,     score_payload(r_snap)};
        endcase
        w_byte = w_sel_idx[0] ? w_word[7:0] : w_word[15:8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= 4'd0;
            r_pending  <= 1'b0;
            r_snap     <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.send_req || r_pending) begin
                        r_snap     <= w_live;
                        r_pending  <= 1'b0;
                        r_idx      <= 4'd0;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_byte;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.send_req) begin
                        r_pending <= 1'b1;
                    end
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.send_req) begin
                        r_pending <= 1'b1;
                    end
                    if (bus.tx_done) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx      <= r_idx + 4'd1;
                            r_tx_start <= 1'b1;
                            r_tx_data  <= w_byte;
                            r_state    <= ST_SEND;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_start = r_tx_start;
    assign bus.tx_data  = r_tx_data;
    assign bus.busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mux
// Purpose  : Randomized bench for uart_mux against a frame-level byte model
// Revision : 1.0
// ============================================================================
module tb_uart_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_mux_if bus ();

    uart_mux #(.SYNC_PAYLOAD(12'h000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] p1x, p1y, p2x, p2y, bx, by;
        logic [3:0]  s1, s2;
        logic        fp, eg;
    } gs_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int cnt      = 0;
    int lat_lo   = 10;
    int lat_hi   = 10;
    int req_cyc  = 0;
    bit spur_en     = 1'b0;
    bit toggle_done = 1'b0;
    logic prev_busy = 1'b0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int start_cyc_q[$];
    int done_cyc_q[$];
    int fall_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // uart_tx stand-in: answers each tx_start with tx_done after a random delay
    initial begin
        logic done;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    done = 1'b1;
                    done_cyc_q.push_back(cyc);
                end
            end
            if (bus.tx_start === 1'b1) begin
                got_q.push_back(bus.tx_data);
                start_cyc_q.push_back(cyc);
                cnt = int'($urandom_range(lat_hi, lat_lo));
                if (spur_en) done = 1'b1;
            end else if (spur_en && bus.busy === 1'b0 && cnt == 0 && $urandom_range(0, 1) == 1) begin
                done = 1'b1;
            end
            if (toggle_done) done = ~bus.tx_done;
            if (prev_busy === 1'b1 && bus.busy === 1'b0) fall_cyc_q.push_back(cyc);
            prev_busy   = bus.busy;
            bus.tx_done = done;
        end
    end

    function automatic gs_t rand_gs();
        gs_t g;
        g.p1x = 12'($urandom); g.p1y = 12'($urandom);
        g.p2x = 12'($urandom); g.p2y = 12'($urandom);
        g.bx  = 12'($urandom); g.by  = 12'($urandom);
        g.s1  = 4'($urandom);  g.s2  = 4'($urandom);
        g.fp  = 1'($urandom);  g.eg  = 1'($urandom);
        return g;
    endfunction

    task automatic apply_gs(input gs_t g);
        bus.pl1_posx  = g.p1x; bus.pl1_posy  = g.p1y;
        bus.pl2_posx  = g.p2x; bus.pl2_posy  = g.p2y;
        bus.ball_posx = g.bx;  bus.ball_posy = g.by;
        bus.pl1_score = g.s1;  bus.pl2_score = g.s2;
        bus.flag_point = g.fp; bus.end_game  = g.eg;
    endtask

    // Reference frame: eight {tag, payload} words, high byte first
    task automatic push_frame(input gs_t g);
        logic [15:0] words [8];
        words[0] = 16'hF000;
        words[1] = {4'h3, g.p1x};
        words[2] = {4'h4, g.p1y};
        words[3] = {4'h1, g.p2x};
        words[4] = {4'h2, g.p2y};
        words[5] = {4'h5, g.bx};
        words[6] = {4'h6, g.by};
        words[7] = 16'h7000 + 16'(g.eg) * 16'd512 + 16'(g.fp) * 16'd256
                 + 16'(g.s1) * 16'd16 + 16'(g.s2);
        for (int w = 0; w < 8; w++) begin
            exp_q.push_back(8'(words[w] / 16'd256));
            exp_q.push_back(8'(words[w] % 16'd256));
        end
    endtask

    task automatic clear_logs();
        got_q.delete(); exp_q.delete();
        start_cyc_q.delete(); done_cyc_q.delete(); fall_cyc_q.delete();
    endtask

    task automatic drive_req();
        @(negedge clk);
        bus.send_req = 1'b1;
        req_cyc = cyc;
        @(negedge clk);
        bus.send_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int streak = 0;
        int n = 0;
        while (streak < 3 && n < 3000) begin
            @(negedge clk);
            n++;
            if (bus.busy === 1'b0 && cnt == 0) streak++;
            else streak = 0;
        end
        check($sformatf("%s_idle", tag), streak, 3);
    endtask

    task automatic wait_done(input int n, input string tag);
        int k = 0;
        while (done_cyc_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check(tag, done_cyc_q.size() >= n, 1);
    endtask

    task automatic compare_frames(input string tag, input int nf, input int first_req);
        int nb = 16 * nf;
        check($sformatf("%s_nbytes", tag), got_q.size(), nb);
        for (int i = 0; i < nb && i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        if (start_cyc_q.size() > 0)
            check($sformatf("%s_latency", tag), start_cyc_q[0] - first_req, 1);
        for (int i = 1; i < nb && i < start_cyc_q.size() && i <= done_cyc_q.size(); i++)
            check($sformatf("%s_gap%0d", tag, i), start_cyc_q[i] - done_cyc_q[i-1],
                  (i % 16 == 0) ? 2 : 1);
        check($sformatf("%s_nfall", tag), fall_cyc_q.size(), nf);
        if (fall_cyc_q.size() > 0 && done_cyc_q.size() >= nb)
            check($sformatf("%s_busy_fall", tag), fall_cyc_q[fall_cyc_q.size()-1] - done_cyc_q[nb-1], 1);
    endtask

    initial begin
        gs_t g;
        int r0;
        bus.send_req = 1'b0;
        apply_gs('0);

        // Reset held with tx_done toggling
        toggle_done = 1'b1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_tx_start", bus.tx_start, 0);
            check("rst_tx_data", bus.tx_data, 0);
            check("rst_busy", bus.busy, 0);
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("idle_tx_start", bus.tx_start, 0);
            check("idle_busy", bus.busy, 0);
        end
        toggle_done = 1'b0;
        repeat (3) @(negedge clk);

        // Directed frame; inputs change the cycle after the request
        clear_logs();
        g = '0; g.p1x = 12'h123; g.s1 = 4'd2; g.s2 = 4'd5; g.fp = 1'b1;
        apply_gs(g);
        drive_req();
        push_frame(g);
        apply_gs(rand_gs());
        wait_idle("f1");
        compare_frames("f1", 1, req_cyc);
        if (got_q.size() >= 16) begin
            check("f1_sync_hi", got_q[0], 8'hF0);
            check("f1_sync_lo", got_q[1], 8'h00);
            check("f1_p1x_hi", got_q[2], 8'h31);
            check("f1_p1x_lo", got_q[3], 8'h23);
            check("f1_score_hi", got_q[14], 8'h71);
            check("f1_score_lo", got_q[15], 8'h25);
        end

        // Random frames, random latencies, optional spurious tx_done
        for (int k = 0; k < 5; k++) begin
            clear_logs();
            lat_lo  = int'($urandom_range(1, 4));
            lat_hi  = lat_lo + int'($urandom_range(0, 8));
            spur_en = (k % 2 == 1);
            g = rand_gs();
            apply_gs(g);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            drive_req();
            push_frame(g);
            apply_gs(rand_gs());
            wait_idle($sformatf("rnd%0d", k));
            compare_frames($sformatf("rnd%0d", k), 1, req_cyc);
        end
        spur_en = 1'b0;

        // Three requests during a frame yield exactly one more frame
        clear_logs();
        lat_lo = 2; lat_hi = 6;
        g = rand_gs();
        apply_gs(g);
        drive_req();
        r0 = req_cyc;
        push_frame(g);
        wait_done(4, "pend_wait");
        repeat (3) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive_req();
        end
        g = rand_gs();
        apply_gs(g);
        push_frame(g);
        wait_idle("pend");
        compare_frames("pend", 2, r0);

        // Reset mid-frame abandons the frame and drops the pending request
        clear_logs();
        lat_lo = 3; lat_hi = 6;
        g = rand_gs();
        apply_gs(g);
        drive_req();
        wait_done(3, "mrst_wait3");
        drive_req();
        wait_done(5, "mrst_wait5");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        repeat (30) @(negedge clk);
        check("mrst_quiet_starts", got_q.size(), 0);
        check("mrst_quiet_busy", bus.busy, 0);
        clear_logs();
        g = rand_gs();
        apply_gs(g);
        drive_req();
        push_frame(g);
        wait_idle("mrst");
        compare_frames("mrst", 1, req_cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
